wb_regfile: RTL and testbench

- Writeback-side consumer of the MEM/WB pipeline register. It selects the final writeback value and commits it to the 32-entry integer register file.
- Serves the two ID-stage read ports, with WB->ID same-cycle bypass, plus one debug read port.
- Keeps a retirement counter of committed instructions.
- Sits between the MEM/WB register outputs and the ID stage. It is the only writer of architectural register state.

---
 rtl/wb_regfile.sv | 93 +++++++++
 tb/tb_wb_regfile.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// Writeback stage register file: selects the writeback value, commits it to
// the integer register file, serves two bypassed ID read ports plus an
// unbypassed debug port, and counts retired instructions.
module wb_regfile #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned CNT_WIDTH  = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] wb_data_wb,
  input  logic [DATA_WIDTH-1:0] mem_rdata_wb,
  input  logic                  memtoreg_wb,
  input  logic                  regwrite_wb,
  input  logic [ADDR_WIDTH-1:0] rd_wb,
  input  logic                  retire_wb,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  output logic [DATA_WIDTH-1:0] rs1_data,
  output logic [DATA_WIDTH-1:0] rs2_data,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_data,
  output logic [DATA_WIDTH-1:0] wb_value,
  output logic [CNT_WIDTH-1:0]  retire_cnt
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [Depth];
  logic [CNT_WIDTH-1:0]  retire_cnt_q;
  logic                  we;

  // Writeback value select and write qualification; bubbles and x0 never write.
  always_comb begin
    wb_value = memtoreg_wb ? mem_rdata_wb : wb_data_wb;
    we       = regwrite_wb & retire_wb & (rd_wb != '0);
  end

  // Register array; entry 0 is never written and stays at its reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we) begin
      regs_q[rd_wb] <= wb_value;
    end
  end

  // Retirement counter, wraps naturally at its width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt_q <= '0;
    end else if (retire_wb) begin
      retire_cnt_q <= retire_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign retire_cnt = retire_cnt_q;

  // ID read port 1 with write-first bypass from WB.
  always_comb begin
    rs1_data = '0;
    if (rs1_addr == '0) begin
      rs1_data = '0;
    end else if (we && (rs1_addr == rd_wb)) begin
      rs1_data = wb_value;
    end else begin
      rs1_data = regs_q[rs1_addr];
    end
  end

  // ID read port 2 with write-first bypass from WB.
  always_comb begin
    rs2_data = '0;
    if (rs2_addr == '0) begin
      rs2_data = '0;
    end else if (we && (rs2_addr == rd_wb)) begin
      rs2_data = wb_value;
    end else begin
      rs2_data = regs_q[rs2_addr];
    end
  end

  // Debug port shows committed state only.
  always_comb begin
    dbg_data = '0;
    if (dbg_addr != '0) begin
      dbg_data = regs_q[dbg_addr];
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed literal checks plus randomized
// traffic compared every cycle against an array-based model.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] wb_data_wb = '0;
  logic [31:0] mem_rdata_wb = '0;
  logic        memtoreg_wb = 1'b0;
  logic        regwrite_wb = 1'b0;
  logic [4:0]  rd_wb = '0;
  logic        retire_wb = 1'b0;
  logic [4:0]  rs1_addr = '0;
  logic [4:0]  rs2_addr = '0;
  logic [4:0]  dbg_addr = '0;

  logic [31:0] rs1_data, rs2_data, dbg_data, wb_value;
  logic [63:0] retire_cnt;
  logic [31:0] s_rs1_data, s_rs2_data, s_dbg_data, s_wb_value;
  logic [3:0]  s_retire_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  // Model state
  logic [31:0] m_regs [32];
  longint unsigned m_cnt = 0;
  int unsigned     m_cnt4 = 0;

  wb_regfile dut (
    .clk(clk), .rst_n(rst_n), .wb_data_wb(wb_data_wb), .mem_rdata_wb(mem_rdata_wb),
    .memtoreg_wb(memtoreg_wb), .regwrite_wb(regwrite_wb), .rd_wb(rd_wb),
    .retire_wb(retire_wb), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .wb_value(wb_value), .retire_cnt(retire_cnt)
  );

  // Narrow-counter instance so wraparound is reachable.
  wb_regfile #(.CNT_WIDTH(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .wb_data_wb(wb_data_wb), .mem_rdata_wb(mem_rdata_wb),
    .memtoreg_wb(memtoreg_wb), .regwrite_wb(regwrite_wb), .rd_wb(rd_wb),
    .retire_wb(retire_wb), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(s_rs1_data), .rs2_data(s_rs2_data), .dbg_addr(dbg_addr),
    .dbg_data(s_dbg_data), .wb_value(s_wb_value), .retire_cnt(s_retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] exp_wbv();
    return memtoreg_wb ? mem_rdata_wb : wb_data_wb;
  endfunction

  function automatic bit exp_we();
    return regwrite_wb && retire_wb && (rd_wb != 5'd0);
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (exp_we() && a == rd_wb) return exp_wbv();
    return m_regs[a];
  endfunction

  function automatic logic [31:0] exp_dbg(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : m_regs[a];
  endfunction

  // Architectural model: what the register file and counters hold after each edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) m_regs[i] <= 32'd0;
      m_cnt  <= 0;
      m_cnt4 <= 0;
    end else begin
      if (exp_we()) m_regs[rd_wb] <= exp_wbv();
      if (retire_wb) begin
        m_cnt  <= m_cnt + 1;
        m_cnt4 <= (m_cnt4 + 1) % 16;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("wb_value", {32'd0, wb_value}, {32'd0, exp_wbv()});
      check("rs1_data", {32'd0, rs1_data}, {32'd0, exp_read(rs1_addr)});
      check("rs2_data", {32'd0, rs2_data}, {32'd0, exp_read(rs2_addr)});
      check("dbg_data", {32'd0, dbg_data}, {32'd0, exp_dbg(dbg_addr)});
      check("retire_cnt", retire_cnt, m_cnt);
      check("small_rs1", {32'd0, s_rs1_data}, {32'd0, exp_read(rs1_addr)});
      check("small_dbg", {32'd0, s_dbg_data}, {32'd0, exp_dbg(dbg_addr)});
      check("small_cnt", {60'd0, s_retire_cnt}, 64'(m_cnt4));
    end
  end

  task automatic idle();
    regwrite_wb  = 1'b0;
    retire_wb    = 1'b0;
    memtoreg_wb  = 1'b0;
    rd_wb        = '0;
    wb_data_wb   = '0;
    mem_rdata_wb = '0;
    rs1_addr     = '0;
    rs2_addr     = '0;
    dbg_addr     = '0;
  endtask

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wr(input logic [4:0] rd, input logic [31:0] d, input bit ret);
    regwrite_wb = 1'b1;
    retire_wb   = ret;
    memtoreg_wb = 1'b0;
    rd_wb       = rd;
    wb_data_wb  = d;
  endtask

  initial begin
    idle();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;

    // Post-reset sweep of all indices on every read port.
    for (int i = 0; i < 32; i++) begin
      next_cycle();
      rs1_addr = 5'(i);
      rs2_addr = 5'(31 - i);
      dbg_addr = 5'(i);
      #1;
      check("reset_rs1", {32'd0, rs1_data}, 64'd0);
      check("reset_rs2", {32'd0, rs2_data}, 64'd0);
      check("reset_dbg", {32'd0, dbg_data}, 64'd0);
    end
    check("reset_cnt", retire_cnt, 64'd0);

    // Write x5 with same-cycle bypass; debug port must not bypass.
    next_cycle();
    idle();
    drive_wr(5'd5, 32'hDEADBEEF, 1'b1);
    rs1_addr = 5'd5;
    dbg_addr = 5'd5;
    #1;
    check("x5_bypass", {32'd0, rs1_data}, 64'h0000_0000_DEAD_BEEF);
    check("x5_dbg_nobypass", {32'd0, dbg_data}, 64'd0);
    next_cycle();
    idle();
    dbg_addr = 5'd5;
    #1;
    check("x5_commit", {32'd0, dbg_data}, 64'h0000_0000_DEAD_BEEF);
    check("x5_cnt", retire_cnt, 64'd1);

    // Load select with both ports bypassing.
    next_cycle();
    regwrite_wb  = 1'b1;
    retire_wb    = 1'b1;
    memtoreg_wb  = 1'b1;
    mem_rdata_wb = 32'h0000_0080;
    wb_data_wb   = 32'h1111_1111;
    rd_wb        = 5'd7;
    rs1_addr     = 5'd7;
    rs2_addr     = 5'd7;
    #1;
    check("ld_wbv", {32'd0, wb_value}, 64'h80);
    check("ld_rs1", {32'd0, rs1_data}, 64'h80);
    check("ld_rs2", {32'd0, rs2_data}, 64'h80);
    next_cycle();
    idle();
    dbg_addr = 5'd7;
    #1;
    check("ld_commit", {32'd0, dbg_data}, 64'h80);
    check("ld_cnt", retire_cnt, 64'd2);

    // Write to x0 retires but never writes or bypasses.
    next_cycle();
    drive_wr(5'd0, 32'hFFFF_FFFF, 1'b1);
    rs1_addr = 5'd0;
    #1;
    check("x0_bypass", {32'd0, rs1_data}, 64'd0);
    next_cycle();
    idle();
    #1;
    check("x0_dbg", {32'd0, dbg_data}, 64'd0);
    check("x0_cnt", retire_cnt, 64'd3);

    // Flushed bubble: no write, no bypass, no count.
    next_cycle();
    drive_wr(5'd3, 32'hAAAA_5555, 1'b0);
    rs1_addr = 5'd3;
    #1;
    check("bubble_bypass", {32'd0, rs1_data}, 64'd0);
    next_cycle();
    idle();
    dbg_addr = 5'd3;
    #1;
    check("bubble_x3", {32'd0, dbg_data}, 64'd0);
    check("bubble_cnt", retire_cnt, 64'd3);

    // Asynchronous reset between edges clears state immediately.
    next_cycle();
    drive_wr(5'd9, 32'h1234_5678, 1'b1);
    next_cycle();
    idle();
    dbg_addr = 5'd9;
    #1;
    check("x9_commit", {32'd0, dbg_data}, 64'h1234_5678);
    check("x9_cnt", retire_cnt, 64'd4);
    #1 rst_n = 1'b0;
    #1;
    check("areset_dbg", {32'd0, dbg_data}, 64'd0);
    check("areset_cnt", retire_cnt, 64'd0);
    check("areset_small_cnt", {60'd0, s_retire_cnt}, 64'd0);
    next_cycle();
    rst_n = 1'b1;

    // Narrow counter wraps from 15 to 0.
    next_cycle();
    retire_wb = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    check("wrap_pre", {60'd0, s_retire_cnt}, 64'd15);
    @(posedge clk);
    #1;
    check("wrap_zero", {60'd0, s_retire_cnt}, 64'd0);
    check("wrap_wide", retire_cnt, 64'd16);
    idle();

    // Randomized traffic with address collisions and occasional async resets.
    for (int n = 0; n < 3000; n++) begin
      next_cycle();
      regwrite_wb  = ($urandom_range(0, 3) != 0);
      retire_wb    = ($urandom_range(0, 4) != 0);
      memtoreg_wb  = $urandom_range(0, 1) == 1;
      wb_data_wb   = $urandom;
      mem_rdata_wb = $urandom;
      rd_wb        = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      rs1_addr     = ($urandom_range(0, 2) == 0) ? rd_wb : 5'($urandom);
      rs2_addr     = ($urandom_range(0, 2) == 0) ? rs1_addr : 5'($urandom);
      dbg_addr     = ($urandom_range(0, 2) == 0) ? rd_wb : 5'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        #2 rst_n = 1'b0;
        #1;
        check("rand_areset_cnt", retire_cnt, 64'd0);
        next_cycle();
        rst_n = 1'b1;
      end
    end

    next_cycle();
    idle();
    @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
